// File: rtl/stage_controller_pkg.sv
// cpu_pkg: shared stage encodings, opcode constants and instruction classes for mycpu
package cpu_pkg;
  typedef enum logic [2:0] {
    STG_IF     = 3'd0,
    STG_ID     = 3'd1,
    STG_EX     = 3'd2,
    STG_MEM    = 3'd3,
    STG_WB     = 3'd4,
    STG_HALTED = 3'd7
  } stage_t;
  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_HALT
  } cls_t;
  localparam logic [4:0] OP_HALT  = 5'h00;
  localparam logic [4:0] OP_LOAD  = 5'h02;
  localparam logic [4:0] OP_STORE = 5'h03;
  localparam logic [4:0] OP_JUMP  = 5'h10;
  // branches occupy 0C..0F, i.e. op[4:2] == 3'b011
  function automatic cls_t op_class(input logic [4:0] op);
    return op == OP_HALT ? CLS_HALT :
           op == OP_LOAD ? CLS_LOAD :
           op == OP_STORE ? CLS_STORE :
           op[4:2] == 3'b011 ? CLS_BRANCH :
           op == OP_JUMP ? CLS_JUMP : CLS_ALU;
  endfunction
endpackage

// File: rtl/stage_controller_if.sv
// stage_controller_if: control inputs and stage/strobe outputs of the sequencer
// master drives isAuto/nextStage/opcode/branchTaken; slave (the sequencer) drives the rest
interface stage_controller_if #(parameter int OP_W = 5, parameter int CNT_W = 16);
  logic             isAuto;
  logic             nextStage;
  logic [OP_W-1:0]  opcode;
  logic             branchTaken;
  logic [2:0]       stage;
  logic             irWrite;
  logic             pcWrite;
  logic             pcSrcBranch;
  logic             memRead;
  logic             memWrite;
  logic             regWrite;
  logic             instDone;
  logic [CNT_W-1:0] instCount;
  modport master (
    output isAuto, nextStage, opcode, branchTaken,
    input  stage, irWrite, pcWrite, pcSrcBranch, memRead, memWrite, regWrite, instDone, instCount
  );
  modport slave (
    input  isAuto, nextStage, opcode, branchTaken,
    output stage, irWrite, pcWrite, pcSrcBranch, memRead, memWrite, regWrite, instDone, instCount
  );
endinterface

// File: rtl/stage_controller_step_pulse.sv
// step_pulse: synchronise, debounce and edge-detect a push-button into one clock pulse
// clk/rst: clock, async active-high reset; clr: discard any pending press
// din: raw button; pulse: single-cycle step request
module step_pulse #(parameter int DEBOUNCE_CYCLES = 4) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic din,
  output logic pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1, s2, armed;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      armed <= 1'b0;
      cnt <= '0;
      pulse <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      pulse <= 1'b0;
      // armed drops after a pulse (or while cleared) so a held button steps once
      if (clr) begin
        cnt <= '0;
        armed <= 1'b0;
      end else if (!s2) begin
        cnt <= '0;
        armed <= 1'b1;
      end else if (armed) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          pulse <= 1'b1;
          armed <= 1'b0;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/stage_controller.sv
// stage_controller: multicycle IF/ID/EX/MEM/WB sequencer with write strobes and retire counter
// clk/rst: clock, async active-high reset; bus: stage_controller_if.slave
// (isAuto/nextStage/opcode/branchTaken in; stage, strobes and instCount out)
module stage_controller
  import cpu_pkg::*;
#(
  parameter int OP_W            = 5,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  stage_controller_if.slave bus
);
  logic press, step, last, br;
  logic ir, pcw, pcs, mr, mw, rw, dn;
  logic [OP_W-1:0] op;
  logic [CNT_W-1:0] cnt;
  cls_t cls;
  stage_t st, nxt;
  step_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.isAuto),
    .din   (bus.nextStage),
    .pulse (press)
  );
  // strobes are combinational, so gate the step with rst to keep them low during reset
  assign step = !rst && (bus.isAuto || press);
  assign op = bus.opcode;
  assign cls = op_class(op[4:0]);
  always_comb begin
    nxt = st;
    ir = 1'b0;
    pcw = 1'b0;
    pcs = 1'b0;
    mr = 1'b0;
    mw = 1'b0;
    rw = 1'b0;
    dn = 1'b0;
    last = cls == CLS_BRANCH || cls == CLS_JUMP;
    br = cls == CLS_JUMP || (cls == CLS_BRANCH && bus.branchTaken);
    case (st)
      STG_IF: begin
        ir = step;
        pcw = step;
        nxt = step ? STG_ID : st;
      end
      STG_ID: begin
        dn = step && cls == CLS_HALT;
        nxt = !step ? st : cls == CLS_HALT ? STG_HALTED : STG_EX;
      end
      STG_EX: begin
        pcw = step && br;
        pcs = step && br;
        dn = step && last;
        nxt = !step ? st : last ? STG_IF :
              (cls == CLS_LOAD || cls == CLS_STORE) ? STG_MEM : STG_WB;
      end
      STG_MEM: begin
        mr = cls == CLS_LOAD;
        mw = step && cls == CLS_STORE;
        dn = mw;
        nxt = !step ? st : cls == CLS_STORE ? STG_IF : STG_WB;
      end
      STG_WB: begin
        rw = step;
        dn = step;
        nxt = step ? STG_IF : st;
      end
      STG_HALTED: nxt = st;
      default: nxt = STG_IF;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= STG_IF;
      cnt <= '0;
    end else begin
      st <= nxt;
      if (dn) cnt <= cnt + 1'b1;
    end
  end
  assign bus.stage = st;
  assign bus.irWrite = ir;
  assign bus.pcWrite = pcw;
  assign bus.pcSrcBranch = pcs;
  assign bus.memRead = mr;
  assign bus.memWrite = mw;
  assign bus.regWrite = rw;
  assign bus.instDone = dn;
  assign bus.instCount = cnt;
endmodule

// File: tb/tb_stage_controller.sv
// tb_stage_controller: scoreboard bench for stage_controller (8-bit counter keeps the wrap run short)
module tb_stage_controller;
  typedef struct {
    string      nm;
    logic [2:0] st;
    logic [6:0] sb;
    logic [7:0] cnt;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] c;
  int nrun = 0;
  int nfail = 0;
  exp_t q[$];
  stage_controller_if #(.OP_W(5), .CNT_W(8)) bus ();
  stage_controller #(.OP_W(5), .DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  always #5 clk = ~clk;
  // strobe vector order: irWrite pcWrite pcSrcBranch memRead memWrite regWrite instDone
  always @(negedge clk) begin : monitor
    exp_t e;
    logic [6:0] sb;
    if (q.size() > 0) begin
      e = q.pop_front();
      sb = {bus.irWrite, bus.pcWrite, bus.pcSrcBranch, bus.memRead, bus.memWrite, bus.regWrite, bus.instDone};
      nrun++;
      if (bus.stage !== e.st || sb !== e.sb || bus.instCount !== e.cnt) begin
        nfail++;
        $display("FAIL %s: got stage=%0d strobes=%b cnt=%0d, want stage=%0d strobes=%b cnt=%0d",
                 e.nm, bus.stage, sb, bus.instCount, e.st, e.sb, e.cnt);
      end
    end
  end
  task automatic chk(input string nm, input logic [2:0] st, input logic [6:0] sb);
    exp_t e;
    e.nm = nm;
    e.st = st;
    e.sb = sb;
    e.cnt = c;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    rst = 1'b1;
    bus.isAuto = 1'b0;
    bus.nextStage = 1'b0;
    bus.opcode = 5'h00;
    bus.branchTaken = 1'b0;
    c = 8'd0;
    idle(2);
    chk("reset", 3'd0, 7'b0000000);
    rst = 1'b0;
    bus.isAuto = 1'b1;
    bus.opcode = 5'h05;
    chk("alu_if", 3'd0, 7'b1100000);
    chk("alu_id", 3'd1, 7'b0000000);
    chk("alu_ex", 3'd2, 7'b0000000);
    chk("alu_wb", 3'd4, 7'b0000011);
    c++;
    bus.opcode = 5'h02;
    chk("ld_if", 3'd0, 7'b1100000);
    chk("ld_id", 3'd1, 7'b0000000);
    chk("ld_ex", 3'd2, 7'b0000000);
    chk("ld_mem", 3'd3, 7'b0001000);
    chk("ld_wb", 3'd4, 7'b0000011);
    c++;
    bus.opcode = 5'h03;
    chk("st_if", 3'd0, 7'b1100000);
    chk("st_id", 3'd1, 7'b0000000);
    chk("st_ex", 3'd2, 7'b0000000);
    chk("st_mem", 3'd3, 7'b0000101);
    c++;
    bus.opcode = 5'h0C;
    bus.branchTaken = 1'b1;
    chk("bt_if", 3'd0, 7'b1100000);
    chk("bt_id", 3'd1, 7'b0000000);
    chk("bt_ex", 3'd2, 7'b0110001);
    c++;
    bus.opcode = 5'h0F;
    bus.branchTaken = 1'b0;
    chk("bn_if", 3'd0, 7'b1100000);
    chk("bn_id", 3'd1, 7'b0000000);
    chk("bn_ex", 3'd2, 7'b0000001);
    c++;
    bus.opcode = 5'h10;
    chk("jmp_if", 3'd0, 7'b1100000);
    chk("jmp_id", 3'd1, 7'b0000000);
    chk("jmp_ex", 3'd2, 7'b0110001);
    c++;
    bus.opcode = 5'h05;
    bus.branchTaken = 1'b1;
    chk("alu_bt_if", 3'd0, 7'b1100000);
    chk("alu_bt_id", 3'd1, 7'b0000000);
    chk("alu_bt_ex", 3'd2, 7'b0000000);
    chk("alu_bt_wb", 3'd4, 7'b0000011);
    c++;
    bus.branchTaken = 1'b0;
    chk("pre_rst_if", 3'd0, 7'b1100000);
    chk("pre_rst_id", 3'd1, 7'b0000000);
    rst = 1'b1;
    c = 8'd0;
    chk("rst_mid_ex", 3'd0, 7'b0000000);
    rst = 1'b0;
    chk("rst_if", 3'd0, 7'b1100000);
    chk("rst_id", 3'd1, 7'b0000000);
    chk("rst_ex", 3'd2, 7'b0000000);
    chk("rst_wb", 3'd4, 7'b0000011);
    c++;
    bus.isAuto = 1'b0;
    chk("man_idle", 3'd0, 7'b0000000);
    bus.nextStage = 1'b1;
    for (int i = 0; i < 6; i++) chk("man_wait", 3'd0, 7'b0000000);
    chk("man_step", 3'd0, 7'b1100000);
    for (int i = 0; i < 13; i++) chk("man_hold", 3'd1, 7'b0000000);
    bus.nextStage = 1'b0;
    for (int i = 0; i < 4; i++) chk("man_rel", 3'd1, 7'b0000000);
    bus.nextStage = 1'b1;
    chk("bounce", 3'd1, 7'b0000000);
    chk("bounce", 3'd1, 7'b0000000);
    bus.nextStage = 1'b0;
    chk("bounce", 3'd1, 7'b0000000);
    bus.nextStage = 1'b1;
    chk("bounce", 3'd1, 7'b0000000);
    chk("bounce", 3'd1, 7'b0000000);
    bus.nextStage = 1'b0;
    for (int i = 0; i < 8; i++) chk("bounce_settle", 3'd1, 7'b0000000);
    bus.nextStage = 1'b1;
    for (int i = 0; i < 6; i++) chk("man2_wait", 3'd1, 7'b0000000);
    chk("man2_step", 3'd1, 7'b0000000);
    chk("man2_ex", 3'd2, 7'b0000000);
    bus.nextStage = 1'b0;
    bus.isAuto = 1'b1;
    chk("auto_ex", 3'd2, 7'b0000000);
    chk("auto_wb", 3'd4, 7'b0000011);
    c++;
    bus.opcode = 5'h10;
    idle((255 - int'(c)) * 3);
    c = 8'd255;
    chk("wrap_if", 3'd0, 7'b1100000);
    chk("wrap_id", 3'd1, 7'b0000000);
    chk("wrap_ex", 3'd2, 7'b0110001);
    c = 8'd0;
    bus.opcode = 5'h00;
    chk("wrap_zero", 3'd0, 7'b1100000);
    chk("halt_id", 3'd1, 7'b0000001);
    c++;
    for (int i = 0; i < 50; i++) chk("halted", 3'd7, 7'b0000000);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      nfail++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end
endmodule
